// File: rtl/spi_ctrl_pkg.sv
// Shared types and default sizing for the two-requester SPI master.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester handshake plus SPI pins for the arbitrated SPI master.
interface spi_master_arbiter_if
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [1:0]            Req;
  logic [DATA_WIDTH-1:0] TxData0;
  logic [DATA_WIDTH-1:0] TxData1;
  logic [1:0]            Gnt;
  logic [1:0]            Done;
  logic [DATA_WIDTH-1:0] RxData;
  logic                  Busy;
  logic                  SCK;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  Req, TxData0, TxData1, MISO,
    output Gnt, Done, RxData, Busy, SCK, CS, MOSI
  );

  modport slave (
    output Req, TxData0, TxData1, MISO,
    input  Gnt, Done, RxData, Busy, SCK, CS, MOSI
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module spi_rr_arbiter (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // one-hot winner, zero when disabled or nobody asks
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// SPI mode-0 master shared by two requesters through a round-robin arbiter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | CS high, SCK low; only state that accepts a request
//   ST_SETUP | CS low, MSB on MOSI, SCK low for CLK_DIV cycles
//   ST_SHIFT | SCK toggles every CLK_DIV cycles, DATA_WIDTH full periods
//   ST_HOLD  | CS still low for CLK_DIV cycles before the Done pulse
module spi_master_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input logic                  Clk,
  input logic                  aRst_n,
  spi_master_arbiter_if.master bus
);

  localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]       DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  grant_en;
  logic [1:0]            win;
  logic                  last_gnt;
  logic [7:0]            div_cnt;
  logic                  div_tc;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  sck;
  logic                  cs;
  logic                  mosi;
  logic [1:0]            gnt_q;
  logic [1:0]            done_q;

  assign div_tc = (div_cnt == 8'd0);

  spi_rr_arbiter u_arb (
    .req      (bus.Req),
    .en       (grant_en),
    .last_gnt (last_gnt),
    .gnt      (win)
  );

  // state register
  always_ff @(posedge Clk) begin
    if (!aRst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // next state; a frame only ends on a falling SCK edge after the last bit
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        grant_en = 1'b1;
        if (bus.Req != 2'b00) state_nxt = ST_SETUP;
      end
      ST_SETUP: if (div_tc) state_nxt = ST_SHIFT;
      ST_SHIFT: if (div_tc && sck && (bit_cnt == LAST_BIT)) state_nxt = ST_HOLD;
      ST_HOLD:  if (div_tc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // divider, bit counter, shift registers and registered pins
  always_ff @(posedge Clk) begin
    if (!aRst_n) begin
      div_cnt  <= DIV_LOAD;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      last_gnt <= 1'b1;
    end else begin
      gnt_q  <= win;
      done_q <= 2'b00;
      if (state == ST_IDLE) div_cnt <= DIV_LOAD;
      else                  div_cnt <= div_tc ? DIV_LOAD : div_cnt - 8'd1;
      case (state)
        ST_IDLE: begin
          if (win != 2'b00) begin
            last_gnt <= win[1];
            tx_sh    <= win[1] ? bus.TxData1 : bus.TxData0;
            mosi     <= win[1] ? bus.TxData1[DATA_WIDTH-1] : bus.TxData0[DATA_WIDTH-1];
            cs       <= 1'b0;
            sck      <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (div_tc) begin
            sck <= ~sck;
            if (!sck) begin
              rx_sh <= {rx_sh[DATA_WIDTH-2:0], bus.MISO};
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
              mosi    <= tx_sh[DATA_WIDTH-2];
            end
          end
        end
        ST_HOLD: begin
          if (div_tc) begin
            cs      <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_sh;
            done_q  <= last_gnt ? 2'b10 : 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Gnt    = gnt_q;
  assign bus.Done   = done_q;
  assign bus.RxData = rx_data;
  assign bus.Busy   = (state != ST_IDLE) || (done_q != 2'b00);
  assign bus.SCK    = sck;
  assign bus.CS     = cs;
  assign bus.MOSI   = mosi;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: cycle-level reference model feeding a scoreboard,
// a byte-wise SPI slave model, and a second instance at CLK_DIV=2 / 16-bit frames.
module tb_spi_master_arbiter;

  localparam int DW    = 8;
  localparam int CD    = 4;
  localparam int FRAME = (2 * DW + 2) * CD;

  typedef struct {
    int           who;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int           g;
    int           d;
  } frame_t;

  logic Clk = 1'b0;
  logic aRst_n;
  always #5 Clk = ~Clk;

  spi_master_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  spi_master_arbiter_if #(.DATA_WIDTH(16)) bus2 ();

  spi_master_arbiter #(.DATA_WIDTH(DW), .CLK_DIV(CD)) u_dut (
    .Clk    (Clk),
    .aRst_n (aRst_n),
    .bus    (bus)
  );

  spi_master_arbiter #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut2 (
    .Clk    (Clk),
    .aRst_n (aRst_n),
    .bus    (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  frame_t        gq[$];
  frame_t        dq[$];
  logic [DW-1:0] slv_q[$];
  int            cyc       = 0;
  int            idle_from = 0;
  int            last      = 1;
  logic          loopback  = 1'b0;
  logic          fixed_en  = 1'b0;
  logic [DW-1:0] fixed_word = '0;

  always @(posedge Clk) begin : model_blk
    frame_t        f;
    int            w;
    logic [DW-1:0] sw;
    if (!aRst_n) begin
      gq.delete();
      dq.delete();
      last      = 1;
      idle_from = cyc + 1;
    end else if (cyc >= idle_from && bus.Req != 2'b00) begin
      if (bus.Req == 2'b11) w = 1 - last;
      else                  w = bus.Req[1] ? 1 : 0;
      sw    = fixed_en ? fixed_word : DW'($urandom);
      f.who = w;
      f.tx  = (w == 1) ? bus.TxData1 : bus.TxData0;
      f.rx  = loopback ? f.tx : sw;
      f.g   = cyc + 1;
      f.d   = cyc + 1 + FRAME;
      idle_from = f.d;
      last      = w;
      gq.push_back(f);
      dq.push_back(f);
      slv_q.push_back(sw);
    end
    cyc = cyc + 1;
  end

  // ---------------- SPI slave: shifts out on SCK falling edges ----------------
  logic          slv_bit = 1'b0;
  logic [DW-1:0] s_sh    = '0;
  logic          s_cs_prev  = 1'b1;
  logic          s_sck_prev = 1'b0;

  assign bus.MISO  = loopback ? bus.MOSI : slv_bit;
  assign bus2.MISO = bus2.MOSI;

  always @(negedge Clk) begin
    if (!bus.CS && s_cs_prev) begin
      chk("slave_word_ready", slv_q.size() > 0, 1);
      if (slv_q.size() > 0) s_sh = slv_q.pop_front();
    end else if (!bus.CS && !bus.SCK && s_sck_prev) begin
      s_sh = {s_sh[DW-2:0], 1'b0};
    end
    slv_bit    = s_sh[DW-1];
    s_cs_prev  = bus.CS;
    s_sck_prev = bus.SCK;
  end

  // ---------------- monitor / scoreboard ----------------
  int            gnt_log[$];
  int            gcyc_log[$];
  logic [DW-1:0] mword = '0;
  int            rises = 0;
  logic          m_sck_prev = 1'b0;
  logic          m_cs_prev  = 1'b1;

  always @(negedge Clk) begin : mon_blk
    logic [1:0] exp_gnt;
    logic [1:0] exp_done;
    logic       exp_busy;
    logic       exp_cs;
    if (!aRst_n) begin
      m_sck_prev = 1'b0;
      m_cs_prev  = 1'b1;
    end else begin
      if (!bus.CS && m_cs_prev) begin
        mword = '0;
        rises = 0;
      end
      if (bus.SCK && !m_sck_prev) begin
        mword = {mword[DW-2:0], bus.MOSI};
        rises++;
      end
      exp_busy = 1'b0;
      exp_cs   = 1'b1;
      if (dq.size() > 0 && cyc >= dq[0].g) begin
        exp_busy = 1'b1;
        exp_cs   = (cyc >= dq[0].d);
      end
      chk("busy", bus.Busy, exp_busy);
      chk("cs", bus.CS, exp_cs);
      if (bus.CS) chk("mosi_idle", bus.MOSI, 0);

      exp_gnt = 2'b00;
      if (gq.size() > 0 && gq[0].g == cyc) exp_gnt = (gq[0].who == 1) ? 2'b10 : 2'b01;
      chk("gnt", bus.Gnt, exp_gnt);
      if (exp_gnt != 2'b00) void'(gq.pop_front());
      if (bus.Gnt != 2'b00) begin
        gnt_log.push_back(bus.Gnt[1] ? 1 : 0);
        gcyc_log.push_back(cyc);
      end

      exp_done = 2'b00;
      if (dq.size() > 0 && dq[0].d == cyc) exp_done = (dq[0].who == 1) ? 2'b10 : 2'b01;
      chk("done", bus.Done, exp_done);
      if (exp_done != 2'b00) begin
        chk("rxdata", bus.RxData, dq[0].rx);
        chk("mosi_word", mword, dq[0].tx);
        chk("sck_rises", rises, DW);
        void'(dq.pop_front());
      end
      m_sck_prev = bus.SCK;
      m_cs_prev  = bus.CS;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.Busy || gq.size() > 0 || dq.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask

  task automatic wait_gnt(input int base, output int who, output int gc);
    int n = 0;
    while (gnt_log.size() <= base && n < 500) begin
      step();
      n++;
    end
    chk("gnt_timeout", n < 500, 1);
    if (gnt_log.size() > base) begin
      who = gnt_log[base];
      gc  = gcyc_log[base];
    end else begin
      who = -1;
      gc  = 0;
    end
  endtask

  task automatic run_dut2();
    logic [15:0] tx;
    int g = -1;
    int d = -1;
    int r = 0;
    int last_rise = -1;
    logic prev = 1'b0;
    tx = 16'($urandom);
    bus2.TxData0 = tx;
    bus2.Req     = 2'b01;
    for (int i = 0; i < 300 && d < 0; i++) begin
      @(negedge Clk);
      if (bus2.Gnt != 2'b00 && g < 0) begin
        chk("dut2_gnt", bus2.Gnt, 2'b01);
        g = i;
        bus2.Req = 2'b00;
      end
      if (bus2.SCK && !prev) begin
        if (last_rise >= 0) chk("dut2_sck_period", i - last_rise, 4);
        last_rise = i;
        r++;
      end
      prev = bus2.SCK;
      if (bus2.Done != 2'b00) begin
        chk("dut2_done", bus2.Done, 2'b01);
        d = i;
      end
    end
    chk("dut2_latency", d - g, 68);
    chk("dut2_rises", r, 16);
    chk("dut2_rxdata", bus2.RxData, tx);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_blk
    int who;
    int gc;
    int base;
    int hold;
    aRst_n       = 1'b0;
    bus.Req      = 2'b00;
    bus.TxData0  = '0;
    bus.TxData1  = '0;
    bus2.Req     = 2'b00;
    bus2.TxData0 = '0;
    bus2.TxData1 = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_cs", bus.CS, 1);
    chk("rst_sck", bus.SCK, 0);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_gnt", bus.Gnt, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_rxdata", bus.RxData, 0);
    step();
    aRst_n = 1'b1;
    step();

    // both requesting for three frames: order 0,1,0
    base = gnt_log.size();
    bus.TxData0 = DW'($urandom);
    bus.TxData1 = DW'($urandom);
    bus.Req     = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(base + k, who, gc);
      bus.TxData0 = DW'($urandom);
      bus.TxData1 = DW'($urandom);
    end
    bus.Req = 2'b00;
    wait_idle();
    chk("rr_order0", gnt_log[base], 0);
    chk("rr_order1", gnt_log[base+1], 1);
    chk("rr_order2", gnt_log[base+2], 0);

    // loopback A5 from requester 0
    loopback    = 1'b1;
    base        = gnt_log.size();
    bus.TxData0 = 8'hA5;
    bus.Req     = 2'b01;
    wait_gnt(base, who, gc);
    bus.Req = 2'b00;
    wait_idle();
    chk("a5_owner", who, 0);
    chk("a5_rxdata", bus.RxData, 8'hA5);
    loopback = 1'b0;

    // one-cycle pulse on requester 1, slave returns C3
    fixed_en    = 1'b1;
    fixed_word  = 8'hC3;
    base        = gnt_log.size();
    bus.TxData1 = 8'h3C;
    bus.Req     = 2'b10;
    step();
    bus.Req = 2'b00;
    wait_gnt(base, who, gc);
    wait_idle();
    chk("pulse_owner", who, 1);
    chk("c3_rxdata", bus.RxData, 8'hC3);
    fixed_en = 1'b0;

    // random request patterns, pending requests during busy
    for (int it = 0; it < 25; it++) begin
      bus.Req = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 90);
      for (int s = 0; s < hold; s++) begin
        bus.TxData0 = DW'($urandom);
        bus.TxData1 = DW'($urandom);
        step();
      end
    end
    bus.Req = 2'b00;
    wait_idle();

    // reset 30 cycles into a frame owned by requester 0
    base    = gnt_log.size();
    bus.Req = 2'b01;
    wait_gnt(base, who, gc);
    bus.Req = 2'b00;
    while (cyc < gc + 30) step();
    aRst_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort_cs", bus.CS, 1);
    chk("abort_sck", bus.SCK, 0);
    chk("abort_mosi", bus.MOSI, 0);
    chk("abort_busy", bus.Busy, 0);
    #1;
    step();
    aRst_n  = 1'b1;
    base    = gnt_log.size();
    bus.Req = 2'b11;
    wait_gnt(base, who, gc);
    bus.Req = 2'b00;
    chk("post_rst_owner", who, 0);
    wait_idle();

    run_dut2();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
